// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and ID results into one register-file write per cycle, oldest first.
// Define WB_BYPASS_EN to add a combinational bypass lookup port (byp_addr/byp_hit/byp_data).
module wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEQW  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [2:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [2:0]  id_addr,
  input  logic [31:0] id_data,
  output logic [2:0]  w_addr,
  output logic        w_enable,
  output logic        w_select,
  output logic [31:0] w_alu,
  output logic [31:0] w_id,
`ifdef WB_BYPASS_EN
  input  logic [2:0]  byp_addr,
  output logic        byp_hit,
  output logic [31:0] byp_data,
`endif
  output logic [7:0]  busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Queue index 0 holds ALU results, index 1 holds ID results.
  logic [2:0]      r_addr [2][DEPTH];
  logic [31:0]     r_data [2][DEPTH];
  logic [SEQW-1:0] r_tag  [2][DEPTH];
  logic [PW-1:0]   r_wp   [2];
  logic [PW-1:0]   r_rp   [2];
  logic [CW-1:0]   r_cnt  [2];
  logic [SEQW-1:0] r_seq;

  logic [1:0]       w_push;
  logic [1:0]       w_head_v;
  logic [1:0]       w_full;
  logic [1:0]       w_pop;
  logic             w_pop_id;
  logic [SEQW-1:0]  w_age;
  logic [PW-1:0]    w_off;
  logic [DEPTH-1:0] w_ent_v [2];

  assign w_push[0] = alu_valid & alu_ready;
  assign w_push[1] = id_valid & id_ready;
  assign alu_ready = rst_n & ~w_full[0];
  assign id_ready  = rst_n & ~w_full[1];

  always_comb begin
    w_head_v = '0;
    w_full   = '0;
    for (int q = 0; q < 2; q++) begin
      w_head_v[q] = (r_cnt[q] != '0);
      w_full[q]   = (r_cnt[q] == CW'(DEPTH));
    end
  end

  // Negative modulo difference means the ALU head arrived first.
  assign w_age    = r_tag[0][r_rp[0]] - r_tag[1][r_rp[1]];
  assign w_pop_id = w_head_v[1] & (~w_head_v[0] | ~w_age[SEQW-1]);
  assign w_pop[1] = w_pop_id;
  assign w_pop[0] = w_head_v[0] & ~w_pop_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 2; q++) begin
        r_wp[q]  <= '0;
        r_rp[q]  <= '0;
        r_cnt[q] <= '0;
      end
      r_seq    <= '0;
      w_enable <= 1'b0;
      w_addr   <= '0;
      w_select <= 1'b0;
      w_alu    <= '0;
      w_id     <= '0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (w_push[q]) r_wp[q] <= r_wp[q] + PW'(1);
        if (w_pop[q])  r_rp[q] <= r_rp[q] + PW'(1);
        r_cnt[q] <= r_cnt[q] + CW'(w_push[q]) - CW'(w_pop[q]);
      end
      r_seq    <= r_seq + SEQW'(w_push[0]) + SEQW'(w_push[1]);
      w_enable <= |w_pop;
      if (|w_pop) begin
        w_addr   <= r_addr[w_pop_id][r_rp[w_pop_id]];
        w_select <= w_pop_id;
        w_alu    <= w_pop_id ? '0 : r_data[0][r_rp[0]];
        w_id     <= w_pop_id ? r_data[1][r_rp[1]] : '0;
      end
    end
  end

  // Payload storage needs no reset; validity comes from the pointers and counts.
  always_ff @(posedge clk) begin
    if (w_push[0]) begin
      r_addr[0][r_wp[0]] <= alu_addr;
      r_data[0][r_wp[0]] <= alu_data;
      r_tag[0][r_wp[0]]  <= r_seq;
    end
    if (w_push[1]) begin
      r_addr[1][r_wp[1]] <= id_addr;
      r_data[1][r_wp[1]] <= id_data;
      r_tag[1][r_wp[1]]  <= r_seq + SEQW'(w_push[0]);
    end
  end

  always_comb begin
    w_off = '0;
    for (int q = 0; q < 2; q++) begin
      w_ent_v[q] = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        w_off         = PW'(k) - r_rp[q];
        w_ent_v[q][k] = ({1'b0, w_off} < r_cnt[q]);
      end
    end
  end

  always_comb begin
    busy = '0;
    if (w_enable) busy[w_addr] = 1'b1;
    for (int q = 0; q < 2; q++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_ent_v[q][k]) busy[r_addr[q][k]] = 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic [SEQW-1:0] w_best_tag;
  logic            w_best_q;
  logic [SEQW-1:0] w_diff;

  // The output register is always older than any queued entry.
  always_comb begin
    byp_hit    = 1'b0;
    byp_data   = '0;
    w_best_tag = '0;
    w_best_q   = 1'b0;
    w_diff     = '0;
    if (w_enable && (w_addr == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = w_alu | w_id;
    end
    for (int q = 0; q < 2; q++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_ent_v[q][k] && (r_addr[q][k] == byp_addr)) begin
          w_diff = r_tag[q][k] - w_best_tag;
          if (!w_best_q || !w_diff[SEQW-1]) begin
            byp_hit    = 1'b1;
            byp_data   = r_data[q][k];
            w_best_tag = r_tag[q][k];
            w_best_q   = 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: writes must retire in global acceptance order.
// Define WB_BYPASS_EN to also check the bypass port.
module tb_wb_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned SEQW  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, alu_ready, id_valid, id_ready;
  logic [2:0]  alu_addr, id_addr, w_addr;
  logic [31:0] alu_data, id_data, w_alu, w_id;
  logic        w_enable, w_select;
  logic [7:0]  busy;
`ifdef WB_BYPASS_EN
  logic [2:0]  byp_addr;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  wb_arbiter #(.DEPTH(DEPTH), .SEQW(SEQW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_addr   (id_addr),
    .id_data   (id_data),
    .w_addr    (w_addr),
    .w_enable  (w_enable),
    .w_select  (w_select),
    .w_alu     (w_alu),
    .w_id      (w_id),
`ifdef WB_BYPASS_EN
    .byp_addr  (byp_addr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [2:0]  addr;
    logic [31:0] data;
  } ent_t;

  // Accepted-but-not-issued entries, in acceptance order.
  ent_t sb[$];
  ent_t last;
  bit   cur_v;
  bit   prev_nonempty;
  bit   alu_took, id_took;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Capture transfers at the active edge; ALU first so it is the older of a same-edge pair.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        alu_took = alu_valid && alu_ready;
        id_took  = id_valid && id_ready;
        if (alu_took) sb.push_back({1'b0, alu_addr, alu_data});
        if (id_took)  sb.push_back({1'b1, id_addr, id_data});
      end
    end
  end

  // Monitor: compare DUT against the model on the opposite edge.
  initial begin
    logic [7:0] exp_busy;
    int na, ni;
`ifdef WB_BYPASS_EN
    logic        exp_hit;
    logic [31:0] exp_bd;
`endif
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("issue_when_pending", {31'b0, w_enable}, {31'b0, prev_nonempty});
        cur_v = 1'b0;
        if (w_enable && sb.size() != 0) begin
          last  = sb.pop_front();
          cur_v = 1'b1;
        end
        chk("w_addr", {29'b0, w_addr}, {29'b0, last.addr});
        chk("w_select", {31'b0, w_select}, {31'b0, last.sel});
        chk("w_alu", w_alu, last.sel ? 32'h0 : last.data);
        chk("w_id", w_id, last.sel ? last.data : 32'h0);
        exp_busy = '0;
        na = 0;
        ni = 0;
        if (cur_v) exp_busy[last.addr] = 1'b1;
        foreach (sb[i]) begin
          exp_busy[sb[i].addr] = 1'b1;
          if (sb[i].sel) ni++; else na++;
        end
        chk("busy", {24'b0, busy}, {24'b0, exp_busy});
        chk("alu_ready", {31'b0, alu_ready}, (na < DEPTH) ? 32'd1 : 32'd0);
        chk("id_ready", {31'b0, id_ready}, (ni < DEPTH) ? 32'd1 : 32'd0);
`ifdef WB_BYPASS_EN
        exp_hit = 1'b0;
        exp_bd  = '0;
        if (cur_v && last.addr == byp_addr) begin
          exp_hit = 1'b1;
          exp_bd  = last.data;
        end
        foreach (sb[i]) begin
          if (sb[i].addr == byp_addr) begin
            exp_hit = 1'b1;
            exp_bd  = sb[i].data;
          end
        end
        chk("byp_hit", {31'b0, byp_hit}, {31'b0, exp_hit});
        chk("byp_data", byp_data, exp_bd);
`endif
        prev_nonempty = (sb.size() != 0);
      end
    end
  end

  // One stimulus cycle; an untaken offer is held unchanged.
  task automatic drive_cycle(input int pa, input int pi);
    @(negedge clk);
    #1;
    if (!alu_valid || alu_took) begin
      alu_valid = ($urandom_range(99) < pa);
      alu_addr  = 3'($urandom_range(7));
      alu_data  = $urandom;
    end
    if (!id_valid || id_took) begin
      id_valid = ($urandom_range(99) < pi);
      id_addr  = 3'($urandom_range(7));
      id_data  = $urandom;
    end
`ifdef WB_BYPASS_EN
    byp_addr = 3'($urandom_range(7));
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    alu_valid = 1'b0;
    id_valid  = 1'b0;
    while ((sb.size() != 0 || w_enable) && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk({name, "_we"}, {31'b0, w_enable}, 32'd0);
    chk({name, "_busy"}, {24'b0, busy}, 32'd0);
  endtask

  task automatic clear_model();
    sb.delete();
    last          = '0;
    cur_v         = 1'b0;
    prev_nonempty = 1'b0;
    alu_took      = 1'b0;
    id_took       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    alu_valid = 1'b0;
    id_valid  = 1'b0;
    alu_addr  = '0;
    id_addr   = '0;
    alu_data  = '0;
    id_data   = '0;
`ifdef WB_BYPASS_EN
    byp_addr  = '0;
`endif
    clear_model();
    #1;
    chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    chk("rst_id_ready", {31'b0, id_ready}, 32'd0);
    chk("rst_we", {31'b0, w_enable}, 32'd0);
    chk("rst_busy", {24'b0, busy}, 32'd0);
    #21 rst_n = 1'b1;

    // Single ALU write: latency and busy window.
    @(negedge clk);
    #1;
    alu_valid = 1'b1;
    alu_addr  = 3'd3;
    alu_data  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    chk("t1_busy_e0", {24'b0, busy}, 32'h08);
    chk("t1_we_e0", {31'b0, w_enable}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_we_e1", {31'b0, w_enable}, 32'd1);
    chk("t1_addr_e1", {29'b0, w_addr}, 32'd3);
    chk("t1_alu_e1", w_alu, 32'hDEADBEEF);
    chk("t1_id_e1", w_id, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_busy_e2", {24'b0, busy}, 32'd0);

    // Same-edge pair to the same register: ALU retires before ID.
    @(negedge clk);
    #1;
    alu_valid = 1'b1;
    alu_addr  = 3'd5;
    alu_data  = 32'd1;
    id_valid  = 1'b1;
    id_addr   = 3'd5;
    id_data   = 32'd2;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    id_valid  = 1'b0;
    @(posedge clk);
    #1;
    chk("t2_first_sel", {31'b0, w_select}, 32'd0);
    chk("t2_first_alu", w_alu, 32'd1);
    @(posedge clk);
    #1;
    chk("t2_second_sel", {31'b0, w_select}, 32'd1);
    chk("t2_second_id", w_id, 32'd2);
    chk("t2_second_addr", {29'b0, w_addr}, 32'd5);

    repeat (200) drive_cycle(60, 60);
    repeat (40) drive_cycle(100, 100);
    for (int i = 0; i < 80; i++) drive_cycle((i % 2 == 0) ? 100 : 0, (i % 2 == 0) ? 0 : 100);
    drain("drain1");

    // Asynchronous reset with traffic in flight.
    repeat (4) drive_cycle(100, 100);
    #1;
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    id_valid  = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, w_enable}, 32'd0);
    chk("mid_rst_busy", {24'b0, busy}, 32'd0);
    chk("mid_rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    chk("mid_rst_w_alu", w_alu, 32'd0);
    chk("mid_rst_w_id", w_id, 32'd0);
    clear_model();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_we", {31'b0, w_enable}, 32'd0);

    repeat (120) drive_cycle(70, 50);
    drain("drain2");

`ifdef WB_BYPASS_EN
    byp_addr  = 3'd2;
    @(negedge clk);
    #1;
    alu_valid = 1'b1;
    alu_addr  = 3'd2;
    alu_data  = 32'h11;
    @(posedge clk);
    #1;
    alu_data = 32'h22;
    chk("byp_e0_data", byp_data, 32'h11);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    chk("byp_e1_hit", {31'b0, byp_hit}, 32'd1);
    chk("byp_e1_data", byp_data, 32'h22);
    @(posedge clk);
    #1;
    chk("byp_e2_data", byp_data, 32'h22);
    @(posedge clk);
    #1;
    chk("byp_e3_hit", {31'b0, byp_hit}, 32'd0);
`endif
    drain("drain3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
